// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot row drive, frame-based debounce and a
// polled STATUS/DATA register pair on the 4-bit-address / 8-bit-data bus.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic [3:0] address,
  input  logic [7:0] din,
  input  logic       writeEnable,
  output logic [7:0] dout
);

  localparam int              CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   ROW_LAST    = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB          = 4'(DEBOUNCE);
  localparam logic [3:0]      ADDR_STATUS = 4'h5;
  localparam logic [3:0]      ADDR_DATA   = 4'h6;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HELD = 1'b1} state_e;

  function automatic logic [4:0] ones16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] index16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    rows_q, rows_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic [11:0]   samp_q, samp_d;
  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          overflow_q, overflow_d;

  logic          last_s, frame_end_s, cls_none_s, cls_single_s;
  logic          latch_s, ack_s, unused_din_s;
  logic [15:0]   frame_s;
  logic [4:0]    ones_s;
  logic [3:0]    code_s, cnt_s;

  assign unused_din_s = ^din;
  assign rows         = rows_q;

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= cols;
      sync2_q <= sync1_q;
    end
  end

  assign last_s      = (row_cnt_q == ROW_LAST);
  assign frame_end_s = last_s & rows_q[3];

  // Row period counter, row rotation and per-row column capture.
  always_comb begin
    rows_d    = rows_q;
    row_cnt_d = row_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    samp_d    = samp_q;
    if (last_s) begin
      row_cnt_d = {CW{1'b0}};
      rows_d    = {rows_q[2:0], rows_q[3]};
      case (rows_q)
        4'b0001: samp_d[3:0]  = sync2_q;
        4'b0010: samp_d[7:4]  = sync2_q;
        4'b0100: samp_d[11:8] = sync2_q;
        default: samp_d       = samp_q;
      endcase
    end else begin
      rows_d = rows_q;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_q    <= 4'b0001;
      row_cnt_q <= {CW{1'b0}};
      samp_q    <= 12'h000;
    end else begin
      rows_q    <= rows_d;
      row_cnt_q <= row_cnt_d;
      samp_q    <= samp_d;
    end
  end

  // Row 3 is classified straight from the synchroniser on its sampling edge.
  assign frame_s      = {sync2_q, samp_q};
  assign ones_s       = ones16(frame_s);
  assign code_s       = index16(frame_s);
  assign cls_none_s   = (ones_s == 5'd0);
  assign cls_single_s = (ones_s == 5'd1);

  // Press FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cand_q  <= cand_d;
    end
  end

  // Press FSM next state, evaluated once per frame.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cand_d  = cand_q;
    cnt_s   = count_q;
    if (frame_end_s) begin
      case (state_q)
        S_IDLE: begin
          if (cls_single_s && (code_s == cand_q)) begin
            cnt_s = count_q + 4'd1;
          end else if (cls_single_s) begin
            cand_d = code_s;
            cnt_s  = 4'd1;
          end else begin
            cnt_s = 4'd0;
          end
          if (cnt_s == DB) begin
            state_d = S_HELD;
            count_d = 4'd0;
          end else begin
            count_d = cnt_s;
          end
        end
        S_HELD: begin
          if (cls_none_s) begin
            cnt_s = count_q + 4'd1;
          end else begin
            cnt_s = 4'd0;
          end
          if (cnt_s == DB) begin
            state_d = S_IDLE;
            count_d = 4'd0;
          end else begin
            count_d = cnt_s;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Latch wins over a same-edge acknowledge; overflow is then cleared.
  always_comb begin
    latch_s     = (state_q == S_IDLE) && (state_d == S_HELD);
    ack_s       = writeEnable && (address == ADDR_STATUS);
    key_valid_d = key_valid_q;
    overflow_d  = overflow_q;
    key_code_d  = key_code_q;
    if (latch_s) begin
      key_valid_d = 1'b1;
      key_code_d  = cand_d;
      overflow_d  = ack_s ? 1'b0 : (key_valid_q | overflow_q);
    end else if (ack_s) begin
      key_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
    case (address)
      ADDR_STATUS: dout = {6'b000000, overflow_q, key_valid_q};
      ADDR_DATA:   dout = {4'b0000, key_code_q};
      default:     dout = 8'h00;
    endcase
  end

  // Bus-visible key registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives cols from rows, a frame-level
// model predicts rows/dout every cycle, and directed literals pin key moments.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] address;
  logic [7:0] din;
  logic       writeEnable;
  logic [7:0] dout;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int rot      = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols),
    .address(address), .din(din), .writeEnable(writeEnable), .dout(dout)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key at (r,c) connects row r to column c.
  assign cols = (rows[0] ? keys[3:0]   : 4'b0000) | (rows[1] ? keys[7:4]   : 4'b0000) |
                (rows[2] ? keys[11:8]  : 4'b0000) | (rows[3] ? keys[15:12] : 4'b0000);

  // Frame-level model state.
  int          m_e     = 0;
  logic [15:0] m_kd1   = 16'h0000;
  logic [15:0] m_kd2   = 16'h0000;
  logic [15:0] m_frame = 16'h0000;
  bit          m_held  = 1'b0;
  int          m_cnt   = 0;
  logic [3:0]  m_cand  = 4'd0;
  logic [3:0]  m_code  = 4'd0;
  bit          m_valid = 1'b0;
  bit          m_ovf   = 1'b0;

  function automatic logic [15:0] key_bit(int r, int c);
    logic [15:0] v;
    v = 16'h0001;
    return v << (r * 4 + c);
  endfunction

  function automatic logic [3:0] exp_rows(int e);
    logic [3:0] v;
    v = 4'b0001;
    return v << ((e / SD) % 4);
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic peek(logic [3:0] a, logic [7:0] exp, string name);
    address = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      case (rot)
        0:       address = 4'h5;
        1:       address = 4'h6;
        default: address = 4'hB;
      endcase
      rot = (rot + 1) % 3;
    end
  endtask

  task automatic wr_status();
    address     = 4'h5;
    din         = 8'($urandom);
    writeEnable = 1'b1;
    cyc(1);
  endtask

  // Model: sampled key matrix per frame, debounce rules applied at frame end.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_e = 0; m_kd1 = 16'h0000; m_kd2 = 16'h0000; m_frame = 16'h0000;
      m_held = 1'b0; m_cnt = 0; m_cand = 4'd0; m_code = 4'd0;
      m_valid = 1'b0; m_ovf = 1'b0;
    end else begin : mstep
      int r, n, code;
      bit ack, latch;
      r     = (m_e / SD) % 4;
      ack   = writeEnable && (address == 4'h5);
      latch = 1'b0;
      if (m_e % SD == SD - 1) m_frame[r*4 +: 4] = m_kd2[r*4 +: 4];
      m_kd2 = m_kd1;
      m_kd1 = keys;
      if (m_e % (4 * SD) == 4 * SD - 1) begin
        n    = $countones(m_frame);
        code = 0;
        for (int i = 0; i < 16; i++) if (m_frame[i]) code = i;
        if (!m_held) begin
          if (n == 1 && code == int'(m_cand)) m_cnt++;
          else if (n == 1) begin m_cand = code[3:0]; m_cnt = 1; end
          else m_cnt = 0;
          if (m_cnt == DB) begin latch = 1'b1; m_held = 1'b1; m_cnt = 0; end
        end else begin
          if (n == 0) m_cnt++;
          else m_cnt = 0;
          if (m_cnt == DB) begin m_held = 1'b0; m_cnt = 0; end
        end
      end
      if (latch) begin
        m_ovf   = m_valid && !ack;
        m_valid = 1'b1;
        m_code  = m_cand;
      end else if (ack) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end
      m_e++;
    end
  end

  // Per-cycle comparison against the model on the inactive clock edge.
  initial forever begin : cmp
    logic [7:0] exp;
    @(negedge clk);
    check("rows", {4'b0000, rows}, {4'b0000, exp_rows(m_e)});
    case (address)
      4'h5:    exp = {6'b000000, m_ovf, m_valid};
      4'h6:    exp = {4'b0000, m_code};
      default: exp = 8'h00;
    endcase
    check($sformatf("dout@%h", address), dout, exp);
  end

  initial begin
    reset_n = 1'b0; keys = 16'h0000; address = 4'h5; din = 8'h00; writeEnable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rows", {4'b0000, rows}, 8'h01);
    peek(4'h5, 8'h00, "reset status");
    peek(4'h6, 8'h00, "reset data");
    reset_n = 1'b1;
    cyc(4);
    check("row step", {4'b0000, rows}, 8'h02);
    cyc(12);
    check("row wrap", {4'b0000, rows}, 8'h01);

    keys = key_bit(2, 1);
    cyc(64);
    peek(4'h5, 8'h01, "press status");
    peek(4'h6, 8'h09, "press data");

    wr_status();
    cyc(47);
    peek(4'h5, 8'h00, "held no repeat");
    keys = 16'h0000;
    cyc(64);
    keys = key_bit(0, 3);
    cyc(64);
    peek(4'h6, 8'h03, "second data");
    peek(4'h5, 8'h01, "second status");
    keys = 16'h0000;
    wr_status();
    cyc(63);

    for (int k = 0; k < 4; k++) begin
      keys = key_bit(2, 1);
      cyc(16);
      keys = 16'h0000;
      cyc(16);
    end
    peek(4'h5, 8'h00, "bounce rejected");

    keys = key_bit(1, 0) | key_bit(3, 2);
    cyc(64);
    peek(4'h5, 8'h00, "ghost rejected");
    keys = 16'h0000;
    cyc(16);

    keys = key_bit(1, 1);
    cyc(64);
    peek(4'h5, 8'h01, "key5 status");
    peek(4'h6, 8'h05, "key5 data");
    keys = 16'h0000;
    cyc(64);
    keys = key_bit(3, 0);
    cyc(64);
    peek(4'h5, 8'h03, "overflow status");
    peek(4'h6, 8'h0C, "overflow data");
    wr_status();
    peek(4'h5, 8'h00, "overflow ack");
    cyc(15);

    keys = 16'h0000;
    cyc(64);
    keys = key_bit(1, 3);
    cyc(64);
    peek(4'h5, 8'h01, "key7 status");
    keys = 16'h0000;
    cyc(64);
    keys = key_bit(2, 2);
    cyc(47);
    wr_status();
    peek(4'h5, 8'h01, "ack+latch status");
    peek(4'h6, 8'h0A, "ack+latch data");

    cyc(5);
    reset_n = 1'b0;
    #1;
    check("midreset rows", {4'b0000, rows}, 8'h01);
    peek(4'h5, 8'h00, "midreset status");
    peek(4'h6, 8'h00, "midreset data");
    cyc(3);
    reset_n = 1'b1;
    cyc(32);
    keys = 16'h0000;
    cyc(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one row at a time and sampling the column lines. It debounces presses over whole scan frames and latches one 4-bit key code per press. It sits beside the display logic inside the peripheral subsystem and exposes a status register and a data register on the same 4-bit-address / 8-bit-data bus, so the CPU can poll for key input.

## Interface
- SCAN_DIV, 1000: clock cycles each row is driven; minimum 4.
- DEBOUNCE, 4: consecutive identical frames needed to accept a press or a release; range 1..15.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rows  out  4  one-hot, active-high row drive.
- cols  in  4  active-high column sense, pulled down externally; asynchronous to clk.
- address  in  4  register address.
- din  in  8  write data (value ignored; only the write event matters).
- writeEnable  in  1  write strobe, sampled on the clk edge.
- dout  out  8  read data, combinational on address.

## Operation
- **Synchronisation:** cols passes through a 2-flop synchroniser before any use.
- **Row scan:** rows rotates 0001 → 0010 → 0100 → 1000 → 0001. Each row is held SCAN_DIV cycles, set by a row-period counter.
- **Column sampling:** synchronised cols is sampled on the last cycle of each row period.
- **Frame:** four row periods, 4*SCAN_DIV cycles. At the end of a frame the four samples are classified:
  - **NONE:** all samples are zero.
  - **SINGLE:** exactly one bit is set across all 16. code = row_index*4 + col_index, where bit n is index n.
  - **MULTI:** more than one bit is set.
- **Press FSM, IDLE** (waiting for a press):
  - SINGLE equal to the candidate: count++.
  - SINGLE with a different code: candidate = code, count = 1.
  - NONE or MULTI: count = 0.
  - When count reaches DEBOUNCE: latch candidate into key_code, set key_valid, go to HELD, count = 0.
- **Press FSM, HELD** (waiting for release):
  - NONE: count++.
  - Any other frame: count = 0.
  - When count reaches DEBOUNCE: go to IDLE, count = 0.
  - No new code is latched while in HELD.
- **Overflow:** a latch that occurs while key_valid = 1 sets overflow and overwrites key_code.
- **Registers:**
  - 4'h5 STATUS, read: {6'b0, overflow, key_valid}. A write of any din clears key_valid and overflow.
  - 4'h6 DATA, read: {4'b0, key_code}. Read-only; writes are ignored.
  - Any other address reads 8'h00.
- Reads have no side effects.

## Timing
- **Reset values:** rows = 4'b0001, row counter = 0, FSM = IDLE, count = 0, candidate = 0, key_code = 0, key_valid = 0, overflow = 0.
- **dout:** reflects the current register contents combinationally; 0 for unmapped addresses.
- **Ack:** a STATUS write takes effect on that clk edge. Flags read 0 from the next cycle.
- **Ack and latch on the same edge:** the latch wins. key_valid = 1 and key_code = new code; overflow = 0, because the old value is considered acknowledged.
- **Press latency:** for a press stable from before a frame start, key_valid rises at the end of the DEBOUNCE-th full frame, plus at most 2 synchroniser cycles of skew. A press arriving mid-frame may cost one extra frame.
- **Frame boundary:** classification, FSM update and latch all happen on the same edge as the final sample of row 3. The row then wraps to 0001 on that edge.
- **Glitches:** a glitch shorter than one row period that misses the sampling cycle is invisible. One that is sampled resets count per the FSM rules.
- **Reset mid-operation:** reset_n low forces all reset values immediately, independent of clk. Any pending candidate is lost.

## Test plan
Bench parameters: SCAN_DIV = 4, DEBOUNCE = 3, so one frame = 16 cycles.

- **Reset:** hold reset_n low. Check rows = 0001, dout at 4'h5 = 8'h00 and at 4'h6 = 8'h00. Release reset and check rows steps 0001 → 0010 every 4 cycles and wraps after 16.
- **Single press:** model key row 2 / col 1, so cols = 4'b0010 whenever rows = 0100. Require STATUS = 8'h01 and DATA = 8'h09 within 4 frames of the press.
- **Ack and no-repeat:** continue holding that key and write 4'h5. Require STATUS = 8'h00 and no new key_valid while held. Release the key for ≥ 4 frames, then press row 0 / col 3. Require DATA = 8'h03 and STATUS = 8'h01.
- **Bounce and ghost rejection:**
  - Toggle the key every other frame: key_valid must never set.
  - Press row 1 / col 0 and row 3 / col 2 together: key_valid stays 0.
- **Overflow:** latch key 5 without ack, release, then latch key 12. Require STATUS = 8'h03 and DATA = 8'h0C. Write 4'h5 and require STATUS = 8'h00.
- **Simultaneous ack and latch:** align a STATUS write with the latching edge. Require STATUS = 8'h01 on the next cycle. Then assert reset_n low mid-frame and require all outputs at reset values.
